// File: rtl/perf_stats_pkg.sv
// Shared constants and opcode classifier for the performance statistics unit.
package perf_stats_pkg;

  // Channel indices; also the rd_sel encoding and ovf bit positions.
  localparam int NUM_CH    = 7;
  localparam int CH_CYC    = 0;
  localparam int CH_R      = 1;
  localparam int CH_IALU   = 2;
  localparam int CH_LOAD   = 3;
  localparam int CH_STORE  = 4;
  localparam int CH_BRANCH = 5;
  localparam int CH_JUMP   = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // One-hot instruction class; the cycle channel has no class bit.
  typedef logic [NUM_CH-1:1] class_vec_t;

  function automatic class_vec_t classify(input logic [5:0] op);
    class_vec_t cls;
    cls = '0;
    case (op)
      OP_RTYPE:                           cls[CH_R]      = 1'b1;
      OP_J, OP_JAL:                       cls[CH_JUMP]   = 1'b1;
      OP_BEQ, OP_BNE:                     cls[CH_BRANCH] = 1'b1;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: cls[CH_LOAD]  = 1'b1;
      OP_SB, OP_SH, OP_SW:                cls[CH_STORE]  = 1'b1;
      default:                            cls[CH_IALU]   = 1'b1;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/perf_stats_unit_counter.sv
// Single event counter with wrap/saturate behaviour and sticky overflow flag.
module perf_counter #(
  parameter int unsigned CNT_W    = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  // Clear has priority over increment; overflow is flagged on the all-ones increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&value) begin
        ovf   <= 1'b1;
        value <= SATURATE ? value : '0;
      end else begin
        value <= value + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_stats_unit.sv
// Instruction-mix and cycle statistics: decode, live counters, shadow bank, read mux.
module perf_stats_unit
  import perf_stats_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [5:0]       op,
  input  logic             count_en,
  input  logic             clear,
  input  logic             snap_req,
  output logic             snap_done,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic [6:0]       ovf
);

  class_vec_t                        cls;
  logic [NUM_CH-1:0]                 inc;
  logic [NUM_CH-1:0][CNT_W-1:0]      live;
  logic [NUM_CH-1:0][CNT_W-1:0]      shadow;

  // Per-channel increment enables: cycles count regardless of retirement.
  always_comb begin
    cls         = classify(op);
    inc         = '0;
    inc[CH_CYC] = count_en;
    for (int i = 1; i < NUM_CH; i++) begin
      inc[i] = count_en & instr_valid & cls[i];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[i]),
      .clr   (clear),
      .value (live[i]),
      .ovf   (ovf[i])
    );
  end

  // Shadow bank captures pre-edge live values, so a simultaneous clear is atomic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow    <= '0;
      snap_done <= 1'b0;
    end else begin
      snap_done <= snap_req;
      if (snap_req) begin
        shadow <= live;
      end
    end
  end

  // Combinational shadow read; select 7 reads zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == 3'(i)) begin
        rd_data = shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_perf_stats_unit.sv
`timescale 1ns/1ps
// Scoreboard bench: two 4-bit instances (wrap and saturate) driven in parallel.
module tb_perf_stats_unit;

  localparam int MAXV = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid, count_en, clear, snap_req;
  logic [5:0] op;
  logic [2:0] rd_sel;
  logic       snap_done_w, snap_done_s;
  logic [3:0] rd_data_w, rd_data_s;
  logic [6:0] ovf_w, ovf_s;

  always #10 clk = ~clk;

  perf_stats_unit #(.CNT_W(4), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .op(op), .count_en(count_en),
    .clear(clear), .snap_req(snap_req), .snap_done(snap_done_w), .rd_sel(rd_sel),
    .rd_data(rd_data_w), .ovf(ovf_w)
  );

  perf_stats_unit #(.CNT_W(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .op(op), .count_en(count_en),
    .clear(clear), .snap_req(snap_req), .snap_done(snap_done_s), .rd_sel(rd_sel),
    .rd_data(rd_data_s), .ovf(ovf_s)
  );

  typedef struct packed {
    logic [6:0][3:0] sw;
    logic [6:0][3:0] ss;
  } exp_t;

  exp_t       q[$];
  int         cnt_w[7];
  int         cnt_s[7];
  logic [6:0] mo_w, mo_s;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference classification straight from the opcode table; 0 would be cycles.
  function automatic int class_of(input logic [5:0] o);
    case (o)
      6'b000000:                                         return 1;
      6'b000010, 6'b000011:                              return 6;
      6'b000100, 6'b000101:                              return 5;
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: return 3;
      6'b101000, 6'b101001, 6'b101011:                   return 4;
      default:                                           return 2;
    endcase
  endfunction

  function automatic void model_zero();
    for (int c = 0; c < 7; c++) begin
      cnt_w[c] = 0;
      cnt_s[c] = 0;
    end
    mo_w = '0;
    mo_s = '0;
  endfunction

  // One clock: apply inputs, advance the model at the edge, queue any snapshot.
  task automatic step(input bit iv, input logic [5:0] o, input bit ce, input bit cl, input bit sn);
    exp_t e;
    bit   hit;
    instr_valid = iv; op = o; count_en = ce; clear = cl; snap_req = sn;
    @(posedge clk);
    for (int c = 0; c < 7; c++) begin
      e.sw[c] = 4'(cnt_w[c]);
      e.ss[c] = 4'(cnt_s[c]);
    end
    for (int c = 0; c < 7; c++) begin
      hit = ce && (c == 0 || (iv && class_of(o) == c));
      if (cl) begin
        cnt_w[c] = 0; cnt_s[c] = 0; mo_w[c] = 1'b0; mo_s[c] = 1'b0;
      end else if (hit) begin
        if (cnt_w[c] == MAXV) begin
          cnt_w[c] = 0; mo_w[c] = 1'b1;
        end else cnt_w[c]++;
        if (cnt_s[c] == MAXV) mo_s[c] = 1'b1;
        else cnt_s[c]++;
      end
    end
    if (sn) q.push_back(e);
    #1;
  endtask

  // Asynchronous reset between edges; outputs must drop without a clock.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("reset snap_done_w", 32'(snap_done_w), 0);
    chk("reset snap_done_s", 32'(snap_done_s), 0);
    chk("reset ovf_w", 32'(ovf_w), 0);
    chk("reset ovf_s", 32'(ovf_s), 0);
    chk("reset rd_data_w", 32'(rd_data_w), 0);
    chk("reset rd_data_s", 32'(rd_data_s), 0);
    model_zero();
    q.delete();
    @(posedge clk);
    #5;
    reset = 1'b0;
  endtask

  // Monitor: every negedge check snap_done and ovf; on a pending snapshot sweep rd_sel.
  initial begin
    exp_t e;
    rd_sel = 3'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("snap_done_w", 32'(snap_done_w), 32'(q.size() > 0));
        chk("snap_done_s", 32'(snap_done_s), 32'(q.size() > 0));
        chk("ovf_w", 32'(ovf_w), 32'(mo_w));
        chk("ovf_s", 32'(ovf_s), 32'(mo_s));
        if (q.size() > 0) begin
          e = q.pop_front();
          for (int sel = 0; sel < 8; sel++) begin
            rd_sel = 3'(sel);
            #1;
            chk($sformatf("rd_w sel%0d", sel), 32'(rd_data_w), sel == 7 ? 0 : 32'(e.sw[sel]));
            chk($sformatf("rd_s sel%0d", sel), 32'(rd_data_s), sel == 7 ? 0 : 32'(e.ss[sel]));
          end
        end
      end
    end
  end

  logic [5:0] ops6 [6];
  logic [5:0] optab [14];

  initial begin
    ops6 = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    optab = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b100000, 6'b100001,
              6'b100011, 6'b100100, 6'b100101, 6'b101000, 6'b101001, 6'b101011, 6'b001000};
    reset = 1'b1;
    instr_valid = 1'b0; op = '0; count_en = 1'b0; clear = 1'b0; snap_req = 1'b0;
    model_zero();
    repeat (2) @(posedge clk);
    #1;
    chk("init ovf_w", 32'(ovf_w), 0);
    chk("init rd_data_w", 32'(rd_data_w), 0);
    #4;
    reset = 1'b0;

    // Ten counting cycles with no retirement, then a snapshot.
    repeat (10) step(1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);

    // One of each class.
    do_reset();
    foreach (ops6[i]) step(1'b1, ops6[i], 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);

    // Seventeen R-type retires: wrap vs saturate.
    do_reset();
    repeat (17) step(1'b1, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);

    // Atomic read-and-reset after five loads, then a follow-up snapshot.
    do_reset();
    repeat (5) step(1'b1, 6'b100011, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000000, 1'b0, 1'b1, 1'b1);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);

    // Frozen counters while retiring, back-to-back snapshots, then reset mid-snapshot.
    repeat (3) step(1'b1, 6'b000000, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 6'b000000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 6'b000000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 6'b000100, 1'b1, 1'b0, 1'b1);
    do_reset();
    step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 800; n++) begin
      logic [5:0] o;
      o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : optab[$urandom_range(0, 13)];
      step($urandom_range(0, 3) != 0, o, $urandom_range(0, 7) != 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    repeat (3) step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #10;
    chk("queue drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perf_stats_unit.md
# perf_stats_unit

Parametrised instruction-mix and cycle statistics unit for the MIPS single-cycle CPU. It decodes the retiring instruction's opcode into six classes and counts each class plus total cycles, with configurable width and either wrap or saturate on overflow. It adds enable/freeze, synchronous clear, atomic snapshot into shadow registers, and sticky overflow flags. It sits beside the datapath and is fed by the same `op` field the control unit decodes.

## Interface
- `CNT_W`, 16, counter and shadow width (≥ 4).
- `SATURATE`, 0, 0 = counters wrap to 0 past all-ones; 1 = counters hold at all-ones.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  reset is asynchronous and active-high; clears all state.
- `instr_valid`  in  1  an instruction retires this cycle; class counters count only when high.
- `op`  in  6  opcode of the retiring instruction.
- `count_en`  in  1  global enable; low freezes every counter, including cycles.
- `clear`  in  1  synchronous clear of live counters and overflow flags.
- `snap_req`  in  1  copy all live counters into the shadow bank.
- `snap_done`  out  1  one-cycle pulse, the cycle after the snapshot is taken.
- `rd_sel`  in  3  shadow select: 0 cycles, 1 R, 2 I-ALU, 3 LOAD, 4 STORE, 5 BRANCH, 6 JUMP, 7 reads 0.
- `rd_data`  out  CNT_W  shadow register chosen by `rd_sel` (combinational).
- `ovf`  out  7  sticky overflow flags, bit index = `rd_sel` encoding 0..6.

## Operation
- Classes: R = `op` 000000; JUMP = 000010, 000011; BRANCH = 000100, 000101; LOAD = 100000, 100001, 100011, 100100, 100101; STORE = 101000, 101001, 101011; I-ALU = every other opcode. Exactly one class is hit per instruction.
- Cycle counter: increments every cycle `count_en`=1, independent of `instr_valid`.
- Class counter: increments when `count_en`=1, `instr_valid`=1, and its class is decoded.
- Overflow: an increment from all-ones sets that channel's `ovf` bit. Counter becomes 0 when `SATURATE`=0 and stays all-ones when `SATURATE`=1. The `ovf` bit stays set until `clear` or `reset`.
- Clear: `clear`=1 zeroes the live counters and `ovf` at the edge. Clear wins over any increment in the same cycle. Shadow registers are not affected.
- Snapshot: `snap_req`=1 loads all seven shadows at the edge with the live values *before* that edge's increment or clear. `snap_done`=1 in the following cycle. Back-to-back `snap_req` is legal, giving one snapshot and one `snap_done` per request cycle.
- `clear` and `snap_req` together: the shadow captures the pre-clear values and the live counters clear. This is the atomic read-and-reset.

## Timing
- Reset values: all live counters 0, all shadows 0, `ovf`=0, `snap_done`=0. `rd_data` is therefore 0.
- Increment latency: 1 cycle. A retire at edge N shows in the live counter after edge N and is visible via snapshot at edge N+1 or later.
- `rd_data` follows `rd_sel` combinationally, with no added cycle.
- Reset asserted mid-snapshot: `snap_done` is suppressed and the shadows read 0.
- With `count_en`=0, `snap_req` and `clear` still operate.

## Structure
- Package `perf_stats_pkg` holds:
  - the class index constants (CYC=0 … JUMP=6) and `NUM_CH`=7;
  - the opcode constants;
  - the combinational function `classify(op)` that returns the one-hot class vector.
- Sub-module `perf_counter`, instantiated 7×: parameters `CNT_W` and `SATURATE`; inputs `inc` and `clr`; outputs `value` and sticky `ovf`.
- The top level holds decode, shadow bank, snapshot pulse and read mux.

## Test plan
- Reset, then 10 cycles with `count_en`=1 and `instr_valid`=0, then `snap_req` → `snap_done` the next cycle; cycles reads 10, all class reads 0.
- Retire `op` sequence 000000, 100011, 101011, 000100, 000010, 001000 with `count_en`=1, then snapshot → each class reads 1, cycles reads 6.
- `CNT_W`=4, `SATURATE`=0, 17 R-type retires → R reads 1, `ovf[1]`=1. Repeat with `SATURATE`=1 → R reads 15, `ovf[1]`=1.
- `clear` and `snap_req` in the same cycle after 5 LOADs → LOAD shadow reads 5. The next snapshot reads 0 and `ovf` is 0.
- `count_en`=0 for 4 cycles while retiring 000000 → no counter changes. Assert `reset` mid-run → all outputs 0 immediately, without waiting for `clk`.
- `rd_sel`=7 → `rd_data`=0. Sweep `rd_sel` 0..6 in one cycle → values match the snapshot.
